// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues word fetches to instruction memory and
// buffers the in-order responses so a decode stall never loses a word.
//
// Ports:
//   clk, rstn          clock; asynchronous reset, ACTIVE-HIGH despite the name
//   imem_req/addr      fetch request and word-aligned address (held until granted)
//   imem_gnt           request accepted this cycle
//   imem_rvalid/rdata  in-order response word
//   hazard_detected_in decode stall: hold the presented instruction
//   br_taken_in        taken branch: flush and redirect to br_target_in
//   br_target_in       redirect address (low two bits ignored)
//   instruction        FIFO head word, or NOP when empty
//   pc_out             FIFO head pc, or last presented pc when empty
//   inst_valid         instruction/pc_out hold a real fetched word
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        hazard_detected_in,
    input  logic        br_taken_in,
    input  logic [31:0] br_target_in,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        inst_valid
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   last_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic [31:0]   buf_word [FIFO_DEPTH];
    logic [31:0]   buf_pc   [FIFO_DEPTH];

    logic          hs;
    logic          rsp;
    logic          push;
    logic          pop;
    logic [CW:0]   credit;
    logic [CW-1:0] out_next;
    logic [31:0]   target;

    assign target     = br_target_in & ~32'h3;
    assign inst_valid = (count != '0);
    assign instruction = inst_valid ? buf_word[rd_ptr] : 32'h0;
    assign pc_out      = inst_valid ? buf_pc[rd_ptr] : last_pc;

    assign pop = inst_valid & ~hazard_detected_in;

    // The head leaving this cycle frees its slot, so it is returned as
    // credit immediately; this keeps a 1-cycle memory streaming at full rate.
    assign credit = {1'b0, count} + {1'b0, outstanding}
                  - {{CW{1'b0}}, pop};

    assign imem_req  = ~rstn & ~br_taken_in
                     & (credit < (CW + 1)'(FIFO_DEPTH));
    assign imem_addr = fetch_pc;

    assign hs  = imem_req & imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp = imem_rvalid & (outstanding != '0);
    assign push = rsp & (discard == '0) & ~br_taken_in;

    assign out_next = outstanding + CW'(hs) - CW'(rsp);

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            last_pc     <= 32'h0;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= out_next;
            if (inst_valid) begin
                last_pc <= pc_out;
            end
            if (br_taken_in) begin
                // Every request still in flight belongs to the old path.
                fetch_pc <= target;
                rsp_pc   <= target;
                discard  <= out_next;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (hs) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_word[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]   <= rsp_pc;
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline; produces the instruction word and its PC that the decode stage consumes.
- Consumes the decode stage's branch-taken and hazard-stall outputs.
- Requests words from instruction memory over a request/grant, in-order response interface.
- Buffers returned words in a small FIFO so a decode stall never loses a fetched instruction; flushes in-flight fetches on a taken branch.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, fetch buffer entries; also the cap on buffered plus outstanding requests (power of 2, at least 2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  reset, asynchronous, ACTIVE-HIGH (1 = reset) despite the name.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  word-aligned fetch address; bits [1:0] always 0.
- imem_gnt  input  1  request accepted this cycle (handshake = imem_req & imem_gnt).
- imem_rvalid  input  1  response word valid; responses return in request order, latency of 1 or more cycles.
- imem_rdata  input  32  response word.
- hazard_detected_in  input  1  decode stall; hold current output instruction.
- br_taken_in  input  1  taken branch/jump resolved in decode.
- br_target_in  input  32  redirect address, valid when br_taken_in=1.
- instruction  output  32  instruction word to decode.
- pc_out  output  32  address of the presented instruction.
- inst_valid  output  1  instruction/pc_out hold a real fetched word.

Behaviour:
- Reset (async assert):
  - fetch_pc = RESET_PC, FIFO empty, outstanding = 0, discard = 0.
  - Outputs: imem_req = 0, imem_addr = RESET_PC, instruction = 32'h0, pc_out = 0, inst_valid = 0.
  - First request is issued the cycle after rstn deasserts.
- Issue:
  - imem_req = 1 when FIFO count + outstanding < FIFO_DEPTH and br_taken_in = 0.
  - imem_addr = fetch_pc.
  - On handshake: fetch_pc += 4 (32-bit wrap from 32'hFFFF_FFFC to 0) and outstanding += 1.
  - imem_req and imem_addr hold stable until granted, unless a redirect occurs.
- Response:
  - On imem_rvalid: outstanding -= 1.
  - If discard > 0: the word is dropped and discard -= 1.
  - Otherwise push {imem_rdata, its pc}, where pc is tracked by a response-pc register incremented by 4 per accepted response.
- Output:
  - FIFO head is presented combinationally: instruction = head word, pc_out = head pc, inst_valid = 1.
  - When the FIFO is empty: instruction = 32'h0 (NOP), pc_out = last value, inst_valid = 0.
  - Head pops on a cycle with inst_valid = 1 and hazard_detected_in = 0.
  - With hazard_detected_in = 1 the head is held; the FIFO fills and issue stops at the credit limit. No word is ever dropped for a stall.
- Push and pop in the same cycle are legal at any occupancy, including full, because the credit rule guarantees space.
- Redirect (br_taken_in = 1), which takes priority over hazard_detected_in:
  - FIFO flushed; fetch_pc = br_target_in & ~32'h3; response-pc = same value.
  - discard = outstanding after this cycle's grant and response are counted. A request granted in the redirect cycle is impossible because imem_req = 0; a response arriving in the redirect cycle is dropped.
  - imem_req = 0 in the redirect cycle; the first request to the target is issued the next cycle.
  - New requests may issue while discard > 0, subject to the credit rule.
- Counters:
  - outstanding and discard are each clog2(FIFO_DEPTH)+1 bits.
  - discard never exceeds outstanding.
  - rvalid with outstanding = 0 is a protocol error; the response is ignored (assertion in the bench).
- Reset mid-operation: all state cleared immediately. Responses arriving after reset with outstanding = 0 are ignored.

Test Plan:
- Reset then zero-wait memory (gnt = 1, rvalid one cycle after grant), no stalls.
  - Required: addresses 0, 4, 8, ... issued back to back.
  - inst_valid rises on cycle 2; pc_out advances by 4 every cycle.
- Stall: assert hazard_detected_in for 5 cycles while head pc = 8.
  - Required: instruction/pc_out hold pc 8.
  - Exactly 2 words are buffered and no further request is issued.
  - After release, pc 8, 12, 16 emerge in consecutive cycles with none lost or duplicated.
- Branch with 2 outstanding requests (memory latency 3): br_taken_in = 1, br_target_in = 32'h0000_0103.
  - Required: imem_req = 0 in the redirect cycle.
  - Next request address is 32'h0000_0100.
  - The 2 stale responses are dropped; the first valid instruction has pc_out = 32'h100.
- br_taken_in and hazard_detected_in both high with a full FIFO.
  - Required: flush occurs, inst_valid = 0 next cycle, fetch resumes at the target.
- PC wrap: RESET_PC = 32'hFFFF_FFF8, no stalls.
  - Required: fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 in order; pc_out matches.
- Reset asserted asynchronously mid-burst with gnt held low.
  - Required: outputs return to reset values without waiting for a clock edge.
  - After release, the first request is to RESET_PC.
